// File: rtl/mag_com_4bit.sv
// Registered WIDTH-bit magnitude comparator with 7485-style cascade inputs.
// Define MAG_COM_SIGNED_EN to compare a/b as two's complement instead of unsigned.
module mag_com_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic             lt_in,
  output logic             e,
  output logic             g,
  output logic             l,
  output logic             out_vld
);

  logic a_gt;
  logic a_lt;
  logic nxt_e;
  logic nxt_g;
  logic nxt_l;

`ifdef MAG_COM_SIGNED_EN
  assign a_gt = $signed(a) > $signed(b);
  assign a_lt = $signed(a) < $signed(b);
`else
  assign a_gt = a > b;
  assign a_lt = a < b;
`endif

  // On equal operands the lower-order stage decides; gt wins over lt, and
  // anything else (including an all-zero cascade) resolves to equal.
  always_comb begin
    nxt_e = 1'b0;
    nxt_g = 1'b0;
    nxt_l = 1'b0;
    if (a_gt) begin
      nxt_g = 1'b1;
    end else if (a_lt) begin
      nxt_l = 1'b1;
    end else if (gt_in) begin
      nxt_g = 1'b1;
    end else if (lt_in) begin
      nxt_l = 1'b1;
    end else begin
      nxt_e = 1'b1;
    end
  end

  // eq_in only matters for documentation of the cascade contract; the
  // resolution above already treats "neither gt nor lt" as equal.
  logic unused_eq;
  assign unused_eq = eq_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e       <= 1'b0;
      g       <= 1'b0;
      l       <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        e <= nxt_e;
        g <= nxt_g;
        l <= nxt_l;
      end
    end
  end

endmodule

// File: tb/tb_mag_com_4bit.sv
// Self-checking bench for mag_com_4bit: directed vector table, hand-written
// hold/reset sequences, and randomized traffic against an integer reference model.
module tb_mag_com_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_vld = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       gt_in = 1'b0;
  logic       eq_in = 1'b1;
  logic       lt_in = 1'b0;
  logic       e, g, l, out_vld;

  int checks = 0;
  int passed = 0;

  // result codes: 0 none, 1 equal, 2 greater, 3 less
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       gi;
    logic       ei;
    logic       li;
    int         exp;
  } vec_t;

  vec_t vecs[$];

  mag_com_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .a(a), .b(b),
    .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in),
    .e(e), .g(g), .l(l), .out_vld(out_vld)
  );

  always #5 clk = ~clk;

  function automatic int to_val(logic [3:0] x);
`ifdef MAG_COM_SIGNED_EN
    return x[3] ? int'(x) - 16 : int'(x);
`else
    return int'(x);
`endif
  endfunction

  function automatic int model(logic [3:0] ta, logic [3:0] tb_v, logic gi, logic li);
    int av = to_val(ta);
    int bv = to_val(tb_v);
    if (av > bv) return 2;
    if (av < bv) return 3;
    if (gi) return 2;
    if (li) return 3;
    return 1;
  endfunction

  function automatic logic [2:0] code_bits(int code);
    case (code)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(string name, int exp_code, logic exp_vld);
    logic [3:0] got;
    logic [3:0] want;
    got  = {e, g, l, out_vld};
    want = {code_bits(exp_code), exp_vld};
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got e,g,l,vld=%b want %b at %0t", name, got, want, $time);
  endtask

  task automatic drive(logic [3:0] ta, logic [3:0] tb_v, logic gi, logic ei, logic li,
                       logic v);
    @(negedge clk);
    a = ta; b = tb_v; gt_in = gi; eq_in = ei; lt_in = li; in_vld = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int last;
    int rv;
    logic [3:0] ra, rb;
    logic rg, re, rl, vld;

    vecs.push_back('{4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd4,  4'd5,  1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{4'd12, 4'd15, 1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{4'd6,  4'd7,  1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{4'd14, 4'd13, 1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'd9,  4'd9,  1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{4'd9,  4'd9,  1'b0, 1'b0, 1'b1, 3});
    vecs.push_back('{4'd9,  4'd9,  1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd9,  4'd9,  1'b1, 1'b0, 1'b1, 2});
    vecs.push_back('{4'd3,  4'd9,  1'b1, 1'b0, 1'b0, 3});
`ifdef MAG_COM_SIGNED_EN
    vecs.push_back('{4'd1,  4'd15, 1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'd14, 4'd13, 1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'd8,  4'd7,  1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{4'd8,  4'd0,  1'b0, 1'b1, 1'b0, 3});
`else
    vecs.push_back('{4'd1,  4'd15, 1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{4'd15, 4'd0,  1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'd0,  4'd15, 1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{4'd8,  4'd7,  1'b0, 1'b1, 1'b0, 2});
`endif

    // reset then idle
    #2;
    check("reset_state", 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'd5, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      check("idle_after_reset", 0, 1'b0);
    end

    // back-to-back directed vectors
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].gi, vecs[i].ei, vecs[i].li, 1'b1);
      check($sformatf("vec%0d", i), vecs[i].exp, 1'b1);
    end

    // hold behaviour after a greater result
    drive(4'd14, 4'd13, 1'b0, 1'b1, 1'b0, 1'b1);
    check("hold_setup_g", 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(4'(i), 4'(i + 7), 1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("hold_%0d", i), 2, 1'b0);
    end

    // async reset between edges while g=1; the concurrent input is dropped
    @(negedge clk);
    #1;
    rst = 1'b1; in_vld = 1'b1; a = 4'd0; b = 4'd0;
    #1;
    check("async_reset_immediate", 0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_wins_over_vld", 0, 1'b0);
    @(negedge clk);
    rst = 1'b0; in_vld = 1'b0;
    @(posedge clk);
    #1;
    check("input_dropped", 0, 1'b0);

    // randomized traffic against the reference model
    last = 0;
    for (int i = 0; i < 300; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      rg  = 1'($urandom);
      re  = 1'($urandom);
      rl  = 1'($urandom);
      vld = ($urandom_range(0, 3) != 0);
      rv  = model(ra, rb, rg, rl);
      drive(ra, rb, rg, re, rl, vld);
      if (vld) last = rv;
      check($sformatf("rand%0d", i), last, vld);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks want completion", checks);
    $fatal(1);
  end

endmodule
